// File: rtl/exe_div_if.sv
// Handshake bundle between the issue stage (IX), the divider and the writeback arbiter (WB).
// A transfer happens on a rising edge where valid and ready are both high; payload is stable while valid waits.
interface exe_div_if;
    logic        ix_div_valid;
    logic        ix_div_ready;
    logic [70:0] ix_div_inf;    // {rd[4:0], rs1[31:0], rs2[31:0], div_control[1:0]}
    logic        div_wb_valid;
    logic        div_wb_ready;
    logic [36:0] div_wb_inf;    // {rd[4:0], result[31:0]}

    modport slave (
        input  ix_div_valid, ix_div_inf, div_wb_ready,
        output ix_div_ready, div_wb_valid, div_wb_inf
    );

    modport master (
        output ix_div_valid, ix_div_inf, div_wb_ready,
        input  ix_div_ready, div_wb_valid, div_wb_inf
    );
endinterface

// File: rtl/exe_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// div_control: 00 DIV, 01 DIVU, 10 REM, 11 REMU (bit0 = unsigned, bit1 = remainder).
module exe_div #(
    parameter int NUM_ITER = 32
) (
    input  logic       clk,
    input  logic       rst,
    exe_div_if.slave   bus,
    output logic [1:0] dbg_state_o
);
    localparam int CW = $clog2(NUM_ITER);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    state_e        state_q;
    logic [4:0]    rd_q;
    logic [1:0]    ctrl_q;
    logic          neg_a_q, neg_b_q;
    logic [31:0]   a_q, b_q, rem_q, quot_q;
    logic [CW-1:0] cnt_q;
    logic          wb_valid_q;
    logic [36:0]   wb_inf_q;

    logic [4:0]  in_rd;
    logic [31:0] in_rs1, in_rs2, in_abs_a, in_abs_b, bypass_res;
    logic [1:0]  in_ctrl;
    logic        in_signed, in_neg_a, in_neg_b, accept, div_zero, ovf;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_d, quot_d, q_fix, r_fix, calc_res;

    always_comb begin
        in_rd     = bus.ix_div_inf[70:66];
        in_rs1    = bus.ix_div_inf[65:34];
        in_rs2    = bus.ix_div_inf[33:2];
        in_ctrl   = bus.ix_div_inf[1:0];
        in_signed = ~in_ctrl[0];
        in_neg_a  = in_signed & in_rs1[31];
        in_neg_b  = in_signed & in_rs2[31];
        in_abs_a  = in_neg_a ? -in_rs1 : in_rs1;
        in_abs_b  = in_neg_b ? -in_rs2 : in_rs2;
        accept    = bus.ix_div_valid && bus.ix_div_ready;
        div_zero  = (in_rs2 == 32'd0);
        ovf       = in_signed && (in_rs1 == 32'h8000_0000) && (in_rs2 == 32'hFFFF_FFFF);
        bypass_res = 32'd0;
        if (div_zero)
            bypass_res = in_ctrl[1] ? in_rs1 : 32'hFFFF_FFFF;
        else if (ovf)
            bypass_res = in_ctrl[1] ? 32'd0 : 32'h8000_0000;

        // Next dividend bit enters from the top of a_q; remainder never exceeds the divisor.
        shifted  = {rem_q, a_q[31]};
        ge       = (shifted >= {1'b0, b_q});
        rem_d    = ge ? 32'(shifted - {1'b0, b_q}) : shifted[31:0];
        quot_d   = {quot_q[30:0], ge};
        q_fix    = (neg_a_q ^ neg_b_q) ? -quot_d : quot_d;
        r_fix    = neg_a_q ? -rem_d : rem_d;
        calc_res = ctrl_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            ctrl_q     <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_inf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    rd_q    <= in_rd;
                    ctrl_q  <= in_ctrl;
                    neg_a_q <= in_neg_a;
                    neg_b_q <= in_neg_b;
                    a_q     <= in_abs_a;
                    b_q     <= in_abs_b;
                    cnt_q   <= '0;
                    rem_q   <= '0;
                    quot_q  <= '0;
                    if (div_zero || ovf) begin
                        wb_inf_q   <= {in_rd, bypass_res};
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q    <= a_q << 1;
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NUM_ITER - 1)) begin
                        wb_inf_q   <= {rd_q, calc_res};
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: if (bus.div_wb_ready) begin
                    wb_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ix_div_ready = (state_q == IDLE) && !rst;
    assign bus.div_wb_valid = wb_valid_q;
    assign bus.div_wb_inf   = wb_inf_q;
    assign dbg_state_o      = state_q;
endmodule

// File: doc/exe_div.md
EXE_DIV -- requirements
Module: exe_div

Interface
REQ-001 SHALL have parameter NUM_ITER, default 32, meaning the number of radix-2 restoring iterations; it SHALL equal XLEN.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port ix_div_valid  input  1  IX offers a DIV-pipe op.
REQ-005 SHALL have port ix_div_ready  output  1  block accepts an op this cycle.
REQ-006 SHALL have port ix_div_inf  input  71  ix_div_inf_t payload: rd[5], rs1[32], rs2[32], div_control[2].
REQ-007 SHALL have port div_wb_valid  output  1  a result is presented to WB.
REQ-008 SHALL have port div_wb_ready  input  1  WB arbiter grants the DIV result this cycle.
REQ-009 SHALL have port div_wb_inf  output  37  div_wb_inf_t payload: rd[5], result[32].

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE.
REQ-011 SHALL drive ix_div_ready high only in IDLE with rst low.
REQ-012 SHALL accept an op on a rising edge where ix_div_valid and ix_div_ready are both high.
REQ-013 SHALL latch rd, div_control, operand signs and absolute values on acceptance.
- Absolute values are taken for DIV/REM only.
- DIVU/REMU operands are used unmodified.
REQ-014 SHALL go IDLE->CALC on acceptance, clearing the iteration counter, remainder and quotient registers, unless REQ-018 applies.
REQ-015 SHALL perform exactly one restoring iteration per cycle in CALC:
- shift {rem,quot} left by 1;
- trial-subtract the divisor on a 33-bit datapath;
- set the quotient LSB when the difference is non-negative;
- increment the counter.
REQ-016 SHALL go CALC->DONE on the edge completing iteration NUM_ITER-1.
- An op accepted on edge N SHALL raise div_wb_valid in the cycle after edge N+32.
REQ-017 SHALL apply sign correction to the result:
- DIV: quotient negated when operand signs differ.
- REM: remainder takes the dividend's sign.
- DIV/DIVU select the quotient; REM/REMU select the remainder.
REQ-018 SHALL bypass CALC on acceptance (IDLE->DONE, valid in the cycle after edge N) in two cases:
- Divisor zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1.
- Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-019 SHALL hold div_wb_valid high and div_wb_inf stable in DONE until div_wb_ready is sampled high.
- DONE->IDLE on that edge.
- div_wb_valid low the following cycle.
REQ-020 SHALL ignore ix_div_valid outside IDLE, with no state or payload change.
REQ-021 SHALL pass rd unchanged to div_wb_inf.rd, including rd=0 (WB suppresses x0 writes).
REQ-022 SHALL keep div_wb_inf.result at its last value when div_wb_valid is low; it carries no meaning in that state.

Reset
REQ-023 SHALL, on any edge with rst high, force:
- state=IDLE;
- div_wb_valid=0, div_wb_inf=0;
- counter, quotient and remainder registers=0.
REQ-024 SHALL hold ix_div_ready=0 while rst is high and return it to 1 the cycle after rst deasserts.
REQ-025 SHALL abandon an op in CALC or DONE when reset mid-operation, with no result emitted afterwards.

Verification
REQ-026 SHALL cover DIVU rs1=100, rs2=7, rd=5, accepted edge N:
- div_wb_valid first high after edge N+32 with result=14, rd=5;
- REMU on the same operands gives 2.
REQ-027 SHALL cover DIV rs1=0xFFFFFFF9 (-7), rs2=2:
- result=0xFFFFFFFD;
- REM gives 0xFFFFFFFF.
REQ-028 SHALL cover divide-by-zero:
- DIV 5/0 gives 0xFFFFFFFF;
- REMU 5/0 gives 5;
- div_wb_valid high in the cycle after acceptance.
REQ-029 SHALL cover overflow DIV 0x80000000/0xFFFFFFFF:
- result=0x80000000 after 1 cycle;
- REM gives 0.
REQ-030 SHALL cover backpressure: div_wb_ready low 10 cycles in DONE with ix_div_valid high throughout:
- valid and payload stable;
- ix_div_ready=0 and no new accept;
- after the ready edge, IDLE, then the pending op is accepted.
REQ-031 SHALL cover rst asserted one cycle at iteration 10 of CALC:
- next cycle: IDLE, div_wb_valid=0, ix_div_ready=1 after deassert;
- no result ever emitted for the aborted op.
